// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// Round-robin arbitration is enabled by defining DATA_MEMORY_ARBITER_RR_EN.
package data_memory_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester and memory-side signal bundle for the data memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface data_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_in;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_out;
  logic                  mem_ready;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_out, mem_ready,
    output done0, done1, rdata, busy,
    output mem_address, mem_in,
    output mem_read, mem_write
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_out, mem_ready,
    input  done0, done1, rdata, busy,
    input  mem_address, mem_in,
    input  mem_read, mem_write
  );

endinterface

// File: rtl/arbiter_grant_select.sv
// Grant policy for the arbiter: round-robin when
// DATA_MEMORY_ARBITER_RR_EN is defined, else port 0 fixed priority.
module arbiter_grant_select
  import data_memory_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DATA_MEMORY_ARBITER_RR_EN
  input  logic last,
`endif
  output logic grant
);

  always_comb begin
    grant = PORT0;
`ifdef DATA_MEMORY_ARBITER_RR_EN
    // contention goes to the port not served last
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = PORT1;
    end
`else
    if (!req0 && req1) begin
      grant = PORT1;
    end
`endif
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Serialises two requesters onto one single-port data memory.
// Define DATA_MEMORY_ARBITER_RR_EN for round-robin contention.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  data_memory_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  grant;
`ifdef DATA_MEMORY_ARBITER_RR_EN
  logic                  last_q, last_d;
`endif

  arbiter_grant_select u_sel (
    .req0  (bus.req0),
    .req1  (bus.req1),
`ifdef DATA_MEMORY_ARBITER_RR_EN
    .last  (last_q),
`endif
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DATA_MEMORY_ARBITER_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          port_d  = grant;
          we_d    = (grant == PORT1) ? bus.we1 : bus.we0;
          addr_d  = (grant == PORT1) ? bus.addr1 : bus.addr0;
          wdata_d = (grant == PORT1) ? bus.wdata1 : bus.wdata0;
`ifdef DATA_MEMORY_ARBITER_RR_EN
          last_d  = grant;
`endif
          state_d = ISSUE;
        end
      end
      // ready may still be high from the previous access here
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.mem_ready) begin
          if (!we_q) begin
            rdata_d = bus.mem_out;
          end
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      port_q  <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DATA_MEMORY_ARBITER_RR_EN
      last_q  <= PORT1;
`endif
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DATA_MEMORY_ARBITER_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_read    = (state_q == ISSUE) && !we_q;
  assign bus.mem_write   = (state_q == ISSUE) && we_q;
  assign bus.done0       = (state_q == DONE) && (port_q == PORT0);
  assign bus.done1       = (state_q == DONE) && (port_q == PORT1);
  assign bus.rdata       = rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_in      = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a transaction-level
// reference model and a small memory whose ready can be delayed.
module tb_data_memory_arbiter;

`ifdef DATA_MEMORY_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  data_memory_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] init_val(logic [7:0] a);
    return 8'(int'(a) * 3 + 7);
  endfunction

  // memory: ready once the last strobed address is presented again
  logic [7:0] tmem [256];
  bit         tv   [256];
  logic [7:0] last_a = 8'h00;
  int         cnt = 0;
  int         extra = 0;

  always @(posedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      last_a <= bus.mem_address;
      cnt    <= extra;
      if (bus.mem_write) begin
        tmem[bus.mem_address] <= bus.mem_in;
        tv[bus.mem_address]   <= 1'b1;
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  assign bus.mem_out   = tv[last_a] ? tmem[last_a] : init_val(last_a);
  assign bus.mem_ready = (bus.mem_address == last_a) && (cnt == 0);

  // reference model: one outstanding transaction, phase 0..3
  int         m_st = 0;
  bit         m_port, m_we, m_last;
  logic [7:0] m_addr, m_wd, m_rd;
  logic [7:0] rmem [256];
  bit         rv   [256];

  function automatic bit pick_port(bit r0, bit r1, bit last);
    if (RR && r0 && r1) return !last;
    return !r0;
  endfunction

  function automatic logic [7:0] ref_rd(logic [7:0] a);
    return rv[a] ? rmem[a] : init_val(a);
  endfunction

  wire m_pick = pick_port(bus.req0, bus.req1, m_last);

  always @(posedge clk) begin
    if (reset) begin
      m_st <= 0; m_port <= 1'b0; m_we <= 1'b0;
      m_addr <= 8'h00; m_wd <= 8'h00; m_rd <= 8'h00;
      m_last <= 1'b1;
    end else begin
      case (m_st)
        0: if (bus.req0 || bus.req1) begin
          m_port <= m_pick;
          m_last <= m_pick;
          m_we   <= m_pick ? bus.we1 : bus.we0;
          m_addr <= m_pick ? bus.addr1 : bus.addr0;
          m_wd   <= m_pick ? bus.wdata1 : bus.wdata0;
          m_st   <= 1;
        end
        1: begin
          if (m_we) begin
            rmem[m_addr] <= m_wd;
            rv[m_addr]   <= 1'b1;
          end
          m_st <= 2;
        end
        2: if (bus.mem_ready) begin
          if (!m_we) m_rd <= ref_rd(m_addr);
          m_st <= 3;
        end
        default: m_st <= 0;
      endcase
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit armed = 1'b0;

  logic       s_d0, s_d1, s_busy, s_rs, s_ws;
  logic [7:0] s_rd, s_addr;
  int         s_cyc;
  int         nw = 0, nb = 0, w_cyc = 0, addr_bad = 0;
  logic       rdy_issue = 1'b0;
  logic [7:0] chk_addr = 8'h00;

  int   t0;
  int   order[$];
  int   dcyc[$];
  int   drd[$];

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one cycle: sample at negedge, compare with model, advance
  task automatic tick();
    logic [28:0] act, exp;
    @(negedge clk);
    s_d0 = bus.done0; s_d1 = bus.done1;
    s_rd = bus.rdata; s_busy = bus.busy;
    s_rs = bus.mem_read; s_ws = bus.mem_write;
    s_addr = bus.mem_address; s_cyc = cyc;
    if (armed) begin
      exp = {m_st != 0, m_st == 1 && !m_we,
             m_st == 1 && m_we,
             m_st == 3 && !m_port, m_st == 3 && m_port,
             m_rd, m_addr, m_wd};
      act = {bus.busy, bus.mem_read, bus.mem_write,
             bus.done0, bus.done1,
             bus.rdata, bus.mem_address, bus.mem_in};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got %h expected %h",
                 cyc, act, exp);
      end
    end
    if (s_ws) begin nw++; w_cyc = cyc; end
    if (s_busy) nb++;
    if (s_rs) rdy_issue = bus.mem_ready;
    if (s_busy && s_addr !== chk_addr) addr_bad++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit r0, input bit r1, input bit hold,
                     input int n, input int budget);
    int k, got;
    k = 0; got = 0;
    order.delete(); dcyc.delete(); drd.delete();
    bus.req0 = r0; bus.req1 = r1; t0 = cyc;
    while (got < n && k < budget) begin
      tick();
      k++;
      if (s_d0) begin
        order.push_back(0); dcyc.push_back(s_cyc - t0);
        drd.push_back(int'(s_rd)); got++;
        if (!hold) bus.req0 = 1'b0;
      end
      if (s_d1) begin
        order.push_back(1); dcyc.push_back(s_cyc - t0);
        drd.push_back(int'(s_rd)); got++;
        if (!hold) bus.req1 = 1'b0;
      end
    end
    chk("done count within budget", got, n);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  initial begin
    int nw0, nb0, ab0, match, gap;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    @(posedge clk);
    #1;
    armed = 1'b1;
    tick();
    chk("reset outputs",
        int'({s_busy, s_d0, s_d1, s_rs, s_ws, s_rd, s_addr}), 0);
    reset = 1'b0;
    tick();

    bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
    nw0 = nw; nb0 = nb;
    run(1, 0, 0, 1, 20);
    chk("t1 done latency", dcyc[0], 3);
    chk("t1 write strobe cycle", w_cyc - t0, 1);
    chk("t1 write strobe count", nw - nw0, 1);
    chk("t1 busy cycles", nb - nb0, 3);

    bus.we0 = 0; bus.wdata0 = 8'h00;
    run(1, 0, 0, 1, 20);
    chk("t2 read rdata", drd[0], 8'hA5);
    chk("t2 done latency", dcyc[0], 3);
    chk("t2 stale ready in issue", int'(rdy_issue), 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    bus.addr0 = 8'h01; bus.addr1 = 8'h02; bus.wdata1 = 8'h3C;
    run(1, 1, 0, 2, 30);
    chk("t3 first port", order[0], 0);
    chk("t3 second port", order[1], 1);
    chk("t3 rdata port0", drd[0], 8'h0A);
    chk("t3 rdata port1", drd[1], 8'h0D);
    chk("t3 done spacing", dcyc[1] - dcyc[0], 4);

    run(1, 0, 0, 1, 20);
    run(1, 1, 0, 2, 30);
    chk("t3 repeat first port", order[0], RR ? 1 : 0);
    chk("t3 repeat first rdata", drd[0], RR ? 8'h0D : 8'h0A);

    run(1, 1, 1, 8, 60);
    match = 0; gap = 0;
    for (int i = 0; i < 8; i++) begin
      if (order[i] == (RR ? ((i % 2 == 0) ? 1 : 0) : 0)) match++;
      if (i > 0 && dcyc[i] - dcyc[i-1] == 4) gap++;
    end
    chk("t4 grant pattern", match, 8);
    chk("t4 done spacing", gap, 7);

    tick();
    extra = 5; bus.we0 = 0; bus.addr0 = 8'h03; bus.req0 = 1;
    tick();
    tick();
    reset = 1'b1; bus.req0 = 0;
    tick();
    reset = 1'b0; extra = 0;
    tick();
    chk("t5 abort state", int'({s_busy, s_d0, s_d1, s_rs, s_ws}), 0);
    chk("t5 rdata cleared", int'(s_rd), 0);
    repeat (6) tick();

    extra = 3; bus.we1 = 0; bus.addr1 = 8'h02;
    chk_addr = 8'h02; ab0 = addr_bad;
    run(0, 1, 0, 1, 30);
    extra = 0;
    chk("t6 delayed latency", dcyc[0], 6);
    chk("t6 address stable", addr_bad - ab0, 0);
    chk("t6 rdata", drd[0], 8'h0D);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
